// File: rtl/mac_table_cam.sv
// 32-entry associative MAC table with learn, lookup and aging, plus the shared package it consumes.
// One request in, one response out a cycle later; the table is register-based so every entry is compared at once.
package mac_table_pkg;
    localparam int PARAM_1 = 5;
    localparam int PARAM_2 = 32;
    localparam int PARAM_3 = 2000;
    localparam int PARAM_4 = 10000;

    typedef logic [7:0] my_type;
    localparam my_type PARAM_LOCAL = 8'hff;

    typedef enum logic [1:0] {
        ENUM_0 = 2'd0,
        ENUM_1 = 2'd1,
        ENUM_2 = 2'd2
    } my_enum_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] age;
        my_type     key;
    } mac_entry_t;

    typedef mac_entry_t [PARAM_2-1:0] T_MAC_TABLE;

    // Returns the lowest set bit position among the first n bits.
    function automatic logic [PARAM_1-1:0] one_hot_to_binary(input logic [PARAM_2-1:0] vec,
                                                              input int n);
        one_hot_to_binary = '0;
        for (int i = PARAM_2 - 1; i >= 0; i--) begin
            if (i < n && vec[i]) one_hot_to_binary = PARAM_1'(i);
        end
    endfunction
endpackage

module mac_table_cam
    import mac_table_pkg::*;
#(
    parameter int AGE_TICK  = PARAM_3,
    parameter int AGE_LIMIT = PARAM_4 / PARAM_3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_learn,
    input  my_type             req_key,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic [PARAM_1-1:0] rsp_index,
    output my_enum_t           rsp_status,
    input  logic               flush,
    output logic [5:0]         occupancy
);
    localparam int ENTRIES = PARAM_2;
    localparam int PS_W    = $clog2(AGE_TICK);

    T_MAC_TABLE         table_q, table_d;
    logic [PS_W-1:0]    prescale_q, prescale_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [PARAM_1-1:0] rsp_index_q, rsp_index_d;
    my_enum_t           rsp_status_q, rsp_status_d;
    logic [5:0]         occupancy_q, occupancy_d;

    logic [ENTRIES-1:0] match, free;
    logic [PARAM_1-1:0] hit_idx, free_idx;
    logic               hit, any_free, tick, accept;
    logic [2:0]         age_inc;

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign tick      = (prescale_q == PS_W'(AGE_TICK - 1));

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = table_q[i].valid && (table_q[i].key == req_key);
            free[i]  = !table_q[i].valid;
        end
    end

    assign hit      = |match;
    assign any_free = |free;
    assign hit_idx  = one_hot_to_binary(match, ENTRIES);
    assign free_idx = one_hot_to_binary(free, ENTRIES);

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        table_d    = table_q;
        prescale_d = tick ? '0 : prescale_q + PS_W'(1);
        age_inc    = '0;

        for (int i = 0; i < ENTRIES; i++) begin
            if (tick && table_q[i].valid) begin
                age_inc = (table_q[i].age == 3'd7) ? 3'd7 : table_q[i].age + 3'd1;
                if (age_inc == 3'(AGE_LIMIT)) begin
                    table_d[i].valid = 1'b0;
                    table_d[i].age   = '0;
                end else begin
                    table_d[i].age = age_inc;
                end
            end
        end

        // Flush overrides everything; a learn written after aging beats a same-cycle eviction.
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_d[i].valid = 1'b0;
                table_d[i].age   = '0;
            end
            prescale_d = '0;
        end else if (accept && req_learn) begin
            if (hit) begin
                table_d[hit_idx].valid = 1'b1;
                table_d[hit_idx].age   = '0;
            end else if (any_free) begin
                table_d[free_idx] = '{valid: 1'b1, age: 3'd0, key: req_key};
            end
        end

        occupancy_d = '0;
        for (int i = 0; i < ENTRIES; i++) occupancy_d = occupancy_d + 6'(table_d[i].valid);
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_index_d  = rsp_index_q;
        rsp_status_d = rsp_status_q;

        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = hit;
            if (req_learn && flush) begin
                rsp_status_d = ENUM_2;
                rsp_index_d  = '0;
            end else if (hit) begin
                rsp_status_d = ENUM_0;
                rsp_index_d  = hit_idx;
            end else if (req_learn && any_free) begin
                rsp_status_d = ENUM_1;
                rsp_index_d  = free_idx;
            end else begin
                rsp_status_d = ENUM_2;
                rsp_index_d  = '0;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: the table is flops rather than a RAM macro, so it is reset along with the control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, age: 3'd0, key: PARAM_LOCAL};
            end
            prescale_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_index_q  <= '0;
            rsp_status_q <= ENUM_0;
            occupancy_q  <= '0;
        end else begin
            table_q      <= table_d;
            prescale_q   <= prescale_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_index_q  <= rsp_index_d;
            rsp_status_q <= rsp_status_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_index  = rsp_index_q;
    assign rsp_status = rsp_status_q;
    assign occupancy  = occupancy_q;
endmodule

// File: tb/tb_mac_table_cam.sv
// Self-checking bench for mac_table_cam: expected responses queued at request acceptance, compared when consumed.
module tb_mac_table_cam;
    import mac_table_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_learn;
    my_type     req_key;
    logic       rsp_valid, rsp_ready, rsp_hit;
    logic [4:0] rsp_index;
    my_enum_t   rsp_status;
    logic       flush;
    logic [5:0] occupancy;

    typedef struct {
        logic       hit;
        logic [4:0] idx;
        my_enum_t   st;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    mac_table_cam dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_learn (req_learn),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_index (rsp_index),
        .rsp_status(rsp_status),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Consumes responses on the handshake and compares them against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_hit", rsp_hit, e.hit);
                check("rsp_index", rsp_index, e.idx);
                check("rsp_status", rsp_status, e.st);
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send(input logic learn, input my_type key, input logic fl,
                        input logic eh, input logic [4:0] ei, input my_enum_t es);
        int waited = 0;
        req_valid = 1'b1;
        req_learn = learn;
        req_key   = key;
        flush     = fl;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("req_ready_timeout", req_ready, 1);
            req_valid = 1'b0;
            flush     = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        sb.push_back('{hit: eh, idx: ei, st: es});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check("latency_1", rsp_valid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_learn = 1'b0;
        req_key   = '0;
        rsp_ready = 1'b1;
        flush     = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_hit", rsp_hit, 0);
        check("reset_rsp_index", rsp_index, 0);
        check("reset_rsp_status", rsp_status, ENUM_0);
        check("reset_occupancy", occupancy, 0);
        check("reset_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Invalid entries hold 8'hff keys and must not match.
        send(1'b0, 8'hff, 1'b0, 1'b0, 5'd0, ENUM_2);
        check("occ_after_reset", occupancy, 0);

        send(1'b1, 8'h12, 1'b0, 1'b0, 5'd0, ENUM_1);
        send(1'b1, 8'h34, 1'b0, 1'b0, 5'd1, ENUM_1);
        send(1'b1, 8'h56, 1'b0, 1'b0, 5'd2, ENUM_1);
        send(1'b0, 8'h34, 1'b0, 1'b1, 5'd1, ENUM_0);
        check("occ_three", occupancy, 3);

        // Backpressure: response A held while request B waits.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_learn = 1'b0;
        req_key   = 8'h56;
        @(negedge clk);
        check("stall_first_ready", req_ready, 1);
        sb.push_back('{hit: 1'b1, idx: 5'd2, st: ENUM_0});
        @(posedge clk);
        #1;
        req_key = 8'h12;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_req_ready", req_ready, 0);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_hit", rsp_hit, 1);
            check("stall_rsp_index", rsp_index, 2);
            check("stall_rsp_status", rsp_status, ENUM_0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_req_ready", req_ready, 1);
        sb.push_back('{hit: 1'b1, idx: 5'd0, st: ENUM_0});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("release_latency_1", rsp_valid, 1);
        @(posedge clk);
        #1;

        // Learn coinciding with flush: nothing committed.
        send(1'b1, 8'h99, 1'b1, 1'b0, 5'd0, ENUM_2);
        check("occ_after_flush_learn", occupancy, 0);
        send(1'b0, 8'h99, 1'b0, 1'b0, 5'd0, ENUM_2);
        send(1'b0, 8'h12, 1'b0, 1'b0, 5'd0, ENUM_2);

        // Fill the table, overflow, then refresh an existing key.
        do_flush();
        for (int i = 0; i < 32; i++) begin
            send(1'b1, my_type'(8'h40 + i), 1'b0, 1'b0, 5'(i), ENUM_1);
        end
        send(1'b1, 8'haa, 1'b0, 1'b0, 5'd0, ENUM_2);
        check("occ_full", occupancy, 32);
        send(1'b1, 8'h45, 1'b0, 1'b1, 5'd5, ENUM_0);
        check("occ_full_after_refresh", occupancy, 32);

        // Aging: evicted on the 5th tick after learning.
        do_flush();
        f = cyc;
        send(1'b1, 8'h12, 1'b0, 1'b0, 5'd0, ENUM_1);
        wait_until(f + 9000);
        send(1'b0, 8'h12, 1'b0, 1'b1, 5'd0, ENUM_0);
        wait_until(f + 10100);
        send(1'b0, 8'h12, 1'b0, 1'b0, 5'd0, ENUM_2);
        check("occ_after_evict", occupancy, 0);

        // Aging: periodic refresh keeps the entry alive.
        do_flush();
        f = cyc;
        send(1'b1, 8'h12, 1'b0, 1'b0, 5'd0, ENUM_1);
        for (int k = 1; k <= 5; k++) begin
            wait_until(f + 6000 * k);
            send(1'b1, 8'h12, 1'b0, 1'b1, 5'd0, ENUM_0);
        end
        wait_until(f + 30500);
        send(1'b0, 8'h12, 1'b0, 1'b1, 5'd0, ENUM_0);
        check("occ_survive", occupancy, 1);

        // Reset with a response pending.
        rsp_ready = 1'b0;
        send(1'b1, 8'h21, 1'b0, 1'b0, 5'd1, ENUM_1);
        rst = 1'b1;
        #1;
        check("midreset_rsp_valid", rsp_valid, 0);
        check("midreset_occupancy", occupancy, 0);
        sb.delete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(1'b1, 8'h77, 1'b0, 1'b0, 5'd0, ENUM_1);
        send(1'b0, 8'h21, 1'b0, 1'b0, 5'd0, ENUM_2);
        send(1'b0, 8'h12, 1'b0, 1'b0, 5'd0, ENUM_2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
